// File: rtl/ram_uart_dumper.sv
// ram_uart_dumper
//   Waits for the program to finish (rising edge on start_dump) and streams a
//   window of data memory out over a UART 8N1 line. Each 32-bit word is read
//   once and sent as four frames, least-significant byte first.
//
// Optional build macro:
//   DUMP_CHECKSUM_EN - appends one extra frame holding the mod-256 sum of all
//                      dumped bytes before the block reports done.
//
// Ports:
//   clk        system clock
//   reset      asynchronous reset, active low
//   start_dump completion level from the processor; its rising edge starts a dump
//   mem_addr   read address into data memory (BASE_ADDR + word_idx*ADDR_STEP)
//   mem_rd     read data returned combinationally for mem_addr
//   tx         UART serial output, idles high
//   busy       high from dump start until the final stop bit completes
//   done       high while waiting in DONE for start_dump to drop
//   byte_out   byte currently on the wire
module ram_uart_dumper #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned NUM_WORDS    = 256,
    parameter logic [31:0] ADDR_STEP    = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_dump,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rd,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [7:0]  byte_out
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t           state, state_d;
    logic             start_q;
    logic             rise;
    logic [CNT_W-1:0] baud_cnt;
    logic             baud_end;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [1:0]       byte_idx;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      word_reg;
    logic             tx_d;
    logic             stop_end;
    logic             last_byte;
    logic             last_word;
    logic             adv_byte;
    logic             adv_word;
    logic             csum_phase;
    logic [7:0]       next_byte;

    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

    assign rise      = start_dump & ~start_q;
    assign baud_end  = (baud_cnt == LAST_CNT);
    assign stop_end  = (state == S_STOP) && baud_end;
    assign last_byte = (byte_idx == 2'd3);
    assign last_word = (word_idx == LAST_WORD);
    assign adv_byte  = stop_end && !csum_phase && !last_byte;
    assign adv_word  = stop_end && !csum_phase && last_byte && !last_word;
    assign next_byte = sel_byte(word_reg, byte_idx + 2'd1);

    assign mem_addr = BASE_ADDR + (32'(word_idx) * ADDR_STEP);
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign done     = (state == S_DONE);

`ifdef DUMP_CHECKSUM_EN
    logic       enter_csum;
    logic [7:0] csum;

    // The checksum frame follows the last data byte directly, with no gap.
    assign enter_csum = stop_end && !csum_phase && last_byte && last_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_phase <= 1'b0;
        end else if (state == S_FETCH) begin
            csum_phase <= 1'b0;
        end else if (enter_csum) begin
            csum_phase <= 1'b1;
        end
    end

    // Each byte is added as it enters START; word 0's FETCH restarts the sum.
    always_ff @(posedge clk) begin
        if (state == S_FETCH) begin
            csum <= (word_idx == '0) ? mem_rd[7:0] : csum + mem_rd[7:0];
        end else if (adv_byte) begin
            csum <= csum + next_byte;
        end
    end
`else
    assign csum_phase = 1'b0;
`endif

    // ---- state register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // ---- next state and next line level ----
    always_comb begin
        state_d   = state;
        bit_idx_d = bit_idx;
        tx_d      = 1'b1;

        if ((state == S_DATA) && baud_end) begin
            bit_idx_d = bit_idx + 3'd1;
        end

        case (state)
            S_IDLE:  if (rise) state_d = S_FETCH;
            S_FETCH: state_d = S_START;
            S_START: if (baud_end) state_d = S_DATA;
            S_DATA:  if (baud_end && (bit_idx == 3'd7)) state_d = S_STOP;
            S_STOP: begin
                if (stop_end) begin
                    if (adv_byte) begin
                        state_d = S_START;
                    end else if (adv_word) begin
                        state_d = S_FETCH;
`ifdef DUMP_CHECKSUM_EN
                    end else if (enter_csum) begin
                        state_d = S_START;
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  if (!start_dump) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // tx is registered from the next state so the line is glitch-free
        // yet stays aligned with the state boundaries.
        if (state_d == S_START) begin
            tx_d = 1'b0;
        end else if (state_d == S_DATA) begin
            tx_d = byte_out[bit_idx_d];
        end
    end

    // ---- control and counters ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q  <= 1'b0;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            word_idx <= '0;
            byte_out <= '0;
        end else begin
            start_q <= start_dump;
            tx      <= tx_d;
            bit_idx <= bit_idx_d;

            if ((state == S_START) || (state == S_DATA) || (state == S_STOP)) begin
                baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
            end else begin
                baud_cnt <= '0;
            end

            // A new dump always begins at BASE_ADDR.
            if (state == S_IDLE) begin
                word_idx <= '0;
            end else if (adv_word) begin
                word_idx <= word_idx + 1'b1;
            end

            if (state == S_FETCH) begin
                byte_idx <= 2'd0;
                byte_out <= mem_rd[7:0];
            end else if (adv_byte) begin
                byte_idx <= byte_idx + 2'd1;
                byte_out <= next_byte;
`ifdef DUMP_CHECKSUM_EN
            end else if (enter_csum) begin
                byte_out <= csum;
`endif
            end
        end
    end

    // ---- word capture ----
    always_ff @(posedge clk) begin
        if (state == S_FETCH) begin
            word_reg <= mem_rd;
        end
    end

endmodule

// File: tb/tb_ram_uart_dumper.sv
// Directed bench for ram_uart_dumper. Two instances share the clock and reset:
// dut_a dumps one word at address 0, dut_b dumps three words from 0x100.
// Expected bytes are queued when a dump is launched and popped as frames are
// decoded off the tx line.
module tb_ram_uart_dumper;

    localparam int CPB = 4;
`ifdef DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [31:0] addr_a, rd_a, addr_b, rd_b;
    logic        tx_a, busy_a, done_a;
    logic        tx_b, busy_b, done_b;
    logic [7:0]  bo_a, bo_b;
    logic [31:0] word_a;
    logic [31:0] mem_b [4];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  sum_model;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rd_a = (addr_a == 32'h0) ? word_a : 32'hDEAD_0000;
    assign rd_b = mem_b[addr_b[3:2]];

    ram_uart_dumper #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0), .NUM_WORDS(1), .ADDR_STEP(32'd4)) dut_a (
        .clk(clk), .reset(reset), .start_dump(start_a), .mem_addr(addr_a), .mem_rd(rd_a),
        .tx(tx_a), .busy(busy_a), .done(done_a), .byte_out(bo_a));

    ram_uart_dumper #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h100), .NUM_WORDS(3), .ADDR_STEP(32'd4)) dut_b (
        .clk(clk), .reset(reset), .start_dump(start_b), .mem_addr(addr_b), .mem_rd(rd_b),
        .tx(tx_b), .busy(busy_b), .done(done_b), .byte_out(bo_b));

    function automatic logic txs(input bit s);
        return s ? tx_b : tx_a;
    endfunction
    function automatic logic dns(input bit s);
        return s ? done_b : done_a;
    endfunction
    function automatic logic [7:0] bos(input bit s);
        return s ? bo_b : bo_a;
    endfunction
    function automatic logic [31:0] adrs(input bit s);
        return s ? addr_b : addr_a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(w[8*i +: 8]);
            sum_model = sum_model + w[8*i +: 8];
        end
    endtask

    // Decode one frame: wait (bounded) for the start bit, then sample mid-bit.
    task automatic recv_frame(input bit s, input logic [31:0] exp_addr, input bit tgl, input int exp_wait);
        int         n;
        logic [7:0] got;
        logic [7:0] exp;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (txs(s) !== 1'b0 && n < 300);
        check("frame_gap", 32'(n), 32'(exp_wait));
        if (txs(s) !== 1'b0) return;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        repeat (CPB / 2) @(negedge clk);
        check("start_bit", 32'(txs(s)), 32'd0);
        check("byte_out", 32'(bos(s)), 32'(exp));
        check("mem_addr", adrs(s), exp_addr);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            got[i] = txs(s);
            if (tgl) start_a = ~start_a;
        end
        check("data_byte", 32'(got), 32'(exp));
        repeat (CPB) @(negedge clk);
        check("stop_bit", 32'(txs(s)), 32'd1);
    endtask

    task automatic wait_done(input bit s);
        int n;
        n = 0;
        while (dns(s) !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_a(input bit tgl, input bit hold);
        int k;
        sum_model = 8'h00;
        push_word(word_a);
        if (CS != 0) exp_q.push_back(sum_model);
        start_a = 1'b1;
        @(negedge clk);
        if (!hold) start_a = 1'b0;
        k = cyc;
        check("busy_on_a", 32'(busy_a), 32'd1);
        check("tx_fetch_a", 32'(tx_a), 32'd1);
        recv_frame(1'b0, 32'h0, tgl, 1);
        for (int f = 1; f < 4 + CS; f++) recv_frame(1'b0, 32'h0, 1'b0, 2);
        wait_done(1'b0);
        check("dump_len_a", 32'(cyc - k), 32'(1 + (4 + CS) * 10 * CPB));
        check("busy_off_a", 32'(busy_a), 32'd0);
        check("tx_done_a", 32'(tx_a), 32'd1);
    endtask

    task automatic run_b();
        int k;
        sum_model = 8'h00;
        for (int w = 0; w < 3; w++) push_word(mem_b[w]);
        if (CS != 0) exp_q.push_back(sum_model);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = cyc;
        check("busy_on_b", 32'(busy_b), 32'd1);
        check("addr_first_b", addr_b, 32'h100);
        for (int f = 0; f < 12 + CS; f++) begin
            int wi;
            wi = (f / 4 > 2) ? 2 : f / 4;
            recv_frame(1'b1, 32'h100 + 32'(4 * wi), 1'b0,
                       (f == 0) ? 1 : ((f % 4 == 0 && f < 12) ? 3 : 2));
        end
        wait_done(1'b1);
        check("dump_len_b", 32'(cyc - k), 32'(3 * (1 + 40 * CPB) + CS * 10 * CPB));
        check("busy_off_b", 32'(busy_b), 32'd0);
        @(negedge clk);
        check("done_clr_b", 32'(done_b), 32'd0);
    endtask

    initial begin
        int bad;
        int n;
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        word_a  = 32'hA5C3_0F81;
        mem_b[0] = 32'h1122_3344;
        mem_b[1] = 32'h5566_7788;
        mem_b[2] = 32'h99AA_BBCC;
        mem_b[3] = 32'hEEEE_EEEE;

        // Reset and idle line
        repeat (5) @(negedge clk);
        check("rst_ctl_a", {29'd0, tx_a, busy_a, done_a}, 32'h4);
        check("rst_byte_a", 32'(bo_a), 32'd0);
        check("rst_addr_b", addr_b, 32'h100);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_ctl_a", {29'd0, tx_a, busy_a, done_a}, 32'h4);
            check("idle_ctl_b", {29'd0, tx_b, busy_b, done_b}, 32'h4);
            check("idle_addr_b", addr_b, 32'h100);
        end

        // Single word with latency and length
        run_a(1'b0, 1'b0);
        check("done_on_a", 32'(done_a), 32'd1);
        @(negedge clk);
        check("done_clr_a", 32'(done_a), 32'd0);

        // Three words with address stepping and inter-word gap
        run_b();

        // Reset in the middle of DATA bit 3 of byte 1
        sum_model = 8'h00;
        push_word(word_a);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        recv_frame(1'b0, 32'h0, 1'b0, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_a !== 1'b0 && n < 300);
        check("abort_gap", 32'(n), 32'd2);
        repeat (CPB / 2 + 4 * CPB) @(negedge clk);
        check("abort_busy_pre", 32'(busy_a), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_tx", 32'(tx_a), 32'd1);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_byte", 32'(bo_a), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
        end
        check("no_resume", 32'(bad), 32'd0);

        // Held start, toggling while busy, re-raise; checksum frame when enabled
        word_a = 32'h0102_03FF;
        run_a(1'b1, 1'b1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done_a !== 1'b1 || busy_a !== 1'b0 || tx_a !== 1'b1) bad++;
        end
        check("hold_done", 32'(bad), 32'd0);
        start_a = 1'b0;
        @(negedge clk);
        check("drop_done", 32'(done_a), 32'd0);
        check("drop_busy", 32'(busy_a), 32'd0);
        run_a(1'b0, 1'b0);

        // Second dump on dut_b restarts at BASE_ADDR
        run_b();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
